// File: rtl/mario_pkg.sv
// Shared constants and types for Mario's motion control: HID keycodes,
// the vertical motion state and a helper that scans the four keycode slots.
package mario_pkg;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic {
    GROUNDED = 1'b0,
    AIRBORNE = 1'b1
  } motion_state_t;

  // True when any of the four 8-bit keycode slots carries the given key.
  function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] key);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (kc[8*i +: 8] == key) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/mario_motion_keycode_decode.sv
// Maps the four-slot USB HID keycode word onto Mario's movement intents.
module keycode_decode
  import mario_pkg::*;
(
  input  logic [31:0] keycode,
  output logic        left,
  output logic        right,
  output logic        jump
);

  assign left  = key_hit(keycode, KEY_A);
  assign right = key_hit(keycode, KEY_D);
  assign jump  = key_hit(keycode, KEY_W) | key_hit(keycode, KEY_SPACE);

endmodule

// File: rtl/mario_motion.sv
// Per-frame Mario motion: horizontal velocity with prescaled acceleration and
// screen clamping, plus a GROUNDED/AIRBORNE machine that replays upstream jump deltas.
module mario_motion
  import mario_pkg::*;
#(
  parameter int START_X     = 64,
  parameter int GROUND_Y    = 400,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 623,
  parameter int MAX_VEL     = 3,
  parameter int JUMP_FRAMES = 40
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [31:0] keycode,
  input  logic [9:0]  jump_y_motion,
  output logic        jump_en,
  output logic [9:0]  mario_x,
  output logic [9:0]  mario_y,
  output logic        on_ground,
  output logic        facing_left,
  output logic [1:0]  anim_frame
);

  localparam logic signed [11:0] X_LO     = 12'(X_MIN);
  localparam logic signed [11:0] X_HI     = 12'(X_MAX);
  localparam logic signed [10:0] Y_GND    = 11'(GROUND_Y);
  localparam logic signed [3:0]  V_MAX    = 4'(MAX_VEL);
  localparam logic [7:0]         AIR_LAST = 8'(JUMP_FRAMES - 1);
  localparam logic [9:0]         X_RST    = 10'(START_X);
  localparam logic [9:0]         Y_RST    = 10'(GROUND_Y);

  logic left, right, jump;

  keycode_decode u_keycode_decode (
    .keycode (keycode),
    .left    (left),
    .right   (right),
    .jump    (jump)
  );

  motion_state_t     state, state_nx;
  logic [9:0]        x_q, x_nx;
  logic [9:0]        y_q, y_nx;
  logic signed [3:0] x_vel, x_vel_nx;
  logic [7:0]        air_cnt, air_cnt_nx;
  logic [1:0]        presc, presc_nx;
  logic [1:0]        anim_q, anim_nx;
  logic [2:0]        anim_div, anim_div_nx;
  logic              face_q, face_nx;
  logic              jump_prev, jump_prev_nx;

  logic signed [10:0] y_sum;
  logic [9:0]         y_clamped;
  logic signed [11:0] x_sum;
  logic signed [3:0]  vel_step;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= GROUNDED;
      x_q       <= X_RST;
      y_q       <= Y_RST;
      x_vel     <= 4'sd0;
      air_cnt   <= 8'd0;
      presc     <= 2'd0;
      anim_q    <= 2'd0;
      anim_div  <= 3'd0;
      face_q    <= 1'b0;
      jump_prev <= 1'b1;
    end else begin
      state     <= state_nx;
      x_q       <= x_nx;
      y_q       <= y_nx;
      x_vel     <= x_vel_nx;
      air_cnt   <= air_cnt_nx;
      presc     <= presc_nx;
      anim_q    <= anim_nx;
      anim_div  <= anim_div_nx;
      face_q    <= face_nx;
      jump_prev <= jump_prev_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    y_nx         = y_q;
    air_cnt_nx   = air_cnt;
    x_nx         = x_q;
    x_vel_nx     = x_vel;
    face_nx      = face_q;
    anim_nx      = anim_q;
    anim_div_nx  = anim_div;
    presc_nx     = presc + 2'd1;
    jump_prev_nx = jump;

    // Rising edge of the jump intent only; jump_prev starts high so a key held through reset cannot fire.
    jump_en = (state == GROUNDED) && jump && !jump_prev;

    y_sum = $signed({1'b0, y_q}) + $signed({jump_y_motion[9], jump_y_motion});
    if (y_sum > Y_GND)       y_clamped = Y_RST;
    else if (y_sum < 11'sd0) y_clamped = 10'd0;
    else                     y_clamped = y_sum[9:0];

    case (state)
      GROUNDED: begin
        if (jump_en) begin
          state_nx   = AIRBORNE;
          air_cnt_nx = 8'd0;
        end
      end
      AIRBORNE: begin
        y_nx       = y_clamped;
        air_cnt_nx = air_cnt + 8'd1;
        if (air_cnt == AIR_LAST) begin
          state_nx = GROUNDED;
          y_nx     = Y_RST;
        end
      end
      default: state_nx = GROUNDED;
    endcase

    // Velocity only moves one step per prescaler wrap; conflicting keys decay like no key.
    vel_step = x_vel;
    if (presc == 2'd3) begin
      if (right && !left) begin
        if (x_vel < V_MAX) vel_step = x_vel + 4'sd1;
      end else if (left && !right) begin
        if (x_vel > -V_MAX) vel_step = x_vel - 4'sd1;
      end else if (x_vel > 4'sd0) begin
        vel_step = x_vel - 4'sd1;
      end else if (x_vel < 4'sd0) begin
        vel_step = x_vel + 4'sd1;
      end
    end

    x_sum = $signed({2'b00, x_q}) + $signed({{8{x_vel[3]}}, x_vel});
    if (x_sum < X_LO) begin
      x_nx     = X_LO[9:0];
      x_vel_nx = 4'sd0;
    end else if (x_sum > X_HI) begin
      x_nx     = X_HI[9:0];
      x_vel_nx = 4'sd0;
    end else begin
      x_nx     = x_sum[9:0];
      x_vel_nx = vel_step;
    end

    if (x_vel_nx < 4'sd0)      face_nx = 1'b1;
    else if (x_vel_nx > 4'sd0) face_nx = 1'b0;

    if ((state == GROUNDED) && (x_vel != 4'sd0)) begin
      anim_div_nx = anim_div + 3'd1;
      if (anim_div == 3'd7) anim_nx = anim_q + 2'd1;
    end else begin
      anim_div_nx = 3'd0;
      anim_nx     = 2'd0;
    end
  end

  assign mario_x     = x_q;
  assign mario_y     = y_q;
  assign on_ground   = (state == GROUNDED);
  assign facing_left = face_q;
  assign anim_frame  = anim_q;

endmodule

// File: tb/tb_mario_motion.sv
// Randomized and directed bench for mario_motion against a frame-level
// integer model of the motion rules.
module tb_mario_motion;

  localparam int T_START_X = 64;
  localparam int T_GROUND  = 400;
  localparam int T_XMIN    = 0;
  localparam int T_XMAX    = 623;
  localparam int T_VMAX    = 3;
  localparam int T_JFRAMES = 40;

  localparam logic [31:0] K_NONE  = 32'h0000_0000;
  localparam logic [31:0] K_A     = 32'h0000_0004;
  localparam logic [31:0] K_D     = 32'h0000_0700;
  localparam logic [31:0] K_AD    = 32'h0004_0007;
  localparam logic [31:0] K_W     = 32'h1A00_0000;
  localparam logic [31:0] K_SPACE = 32'h002C_0000;

  logic        frame_clk = 1'b0;
  logic        Reset_n   = 1'b1;
  logic [31:0] keycode   = '0;
  logic [9:0]  jump_y_motion = '0;
  logic        jump_en;
  logic [9:0]  mario_x;
  logic [9:0]  mario_y;
  logic        on_ground;
  logic        facing_left;
  logic [1:0]  anim_frame;

  always #5 frame_clk = ~frame_clk;

  mario_motion dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .keycode       (keycode),
    .jump_y_motion (jump_y_motion),
    .jump_en       (jump_en),
    .mario_x       (mario_x),
    .mario_y       (mario_y),
    .on_ground     (on_ground),
    .facing_left   (facing_left),
    .anim_frame    (anim_frame)
  );

  int n_checks = 0;
  int n_errors = 0;
  int jen_pulses = 0;
  int air_frames = 0;

  logic [23:0] exp_q[$];

  int m_air, m_x, m_y, m_vel, m_cnt, m_presc, m_anim, m_div, m_face, m_jprev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit has_key(input logic [31:0] kc, input logic [7:0] k);
    bit hit;
    hit = 0;
    for (int i = 0; i < 4; i++) if (kc[8*i +: 8] == k) hit = 1;
    return hit;
  endfunction

  function automatic bit want_jump(input logic [31:0] kc);
    return has_key(kc, 8'h1A) || has_key(kc, 8'h2C);
  endfunction

  function automatic int model_jen(input logic [31:0] kc);
    return (m_air == 0 && want_jump(kc) && m_jprev == 0) ? 1 : 0;
  endfunction

  function automatic logic [9:0] jy(input int v);
    logic [31:0] t;
    t = v;
    return t[9:0];
  endfunction

  task automatic push_expected();
    logic [9:0] ex, ey;
    logic [1:0] ea;
    ex = m_x[9:0];
    ey = m_y[9:0];
    ea = m_anim[1:0];
    exp_q.push_back({ex, ey, (m_air == 0), (m_face != 0), ea});
  endtask

  task automatic model_reset();
    m_air = 0; m_x = T_START_X; m_y = T_GROUND; m_vel = 0; m_cnt = 0;
    m_presc = 0; m_anim = 0; m_div = 0; m_face = 0; m_jprev = 1;
    push_expected();
  endtask

  // One frame of Mario's rules, evaluated from the state seen before the edge.
  task automatic model_step(input logic [31:0] kc, input logic [9:0] jym);
    bit l, r, j;
    int jen, old_air, old_vel, dy, ny, nx, nvel;
    l = has_key(kc, 8'h04);
    r = has_key(kc, 8'h07);
    j = want_jump(kc);
    jen = model_jen(kc);
    old_air = m_air;
    old_vel = m_vel;
    dy = jym[9] ? int'(jym) - 1024 : int'(jym);
    if (m_air != 0) begin
      ny = m_y + dy;
      if (ny > T_GROUND) ny = T_GROUND;
      if (ny < 0) ny = 0;
      m_y = ny;
      if (m_cnt == T_JFRAMES - 1) begin
        m_air = 0;
        m_y = T_GROUND;
      end
      m_cnt++;
    end else if (jen != 0) begin
      m_air = 1;
      m_cnt = 0;
    end
    nx = m_x + m_vel;
    nvel = m_vel;
    if (m_presc == 3) begin
      if (r && !l)      nvel = (m_vel < T_VMAX) ? m_vel + 1 : m_vel;
      else if (l && !r) nvel = (m_vel > -T_VMAX) ? m_vel - 1 : m_vel;
      else if (m_vel > 0) nvel = m_vel - 1;
      else if (m_vel < 0) nvel = m_vel + 1;
    end
    if (nx < T_XMIN) begin nx = T_XMIN; nvel = 0; end
    else if (nx > T_XMAX) begin nx = T_XMAX; nvel = 0; end
    m_x = nx;
    m_vel = nvel;
    if (m_vel < 0) m_face = 1;
    else if (m_vel > 0) m_face = 0;
    if (old_air == 0 && old_vel != 0) begin
      if (m_div == 7) m_anim = (m_anim + 1) % 4;
      m_div = (m_div + 1) % 8;
    end else begin
      m_anim = 0;
      m_div = 0;
    end
    m_presc = (m_presc + 1) % 4;
    m_jprev = j ? 1 : 0;
    push_expected();
  endtask

  task automatic compare_outputs();
    logic [23:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("mario_x", mario_x, e[23:14]);
      check("mario_y", mario_y, e[13:4]);
      check("on_ground", on_ground, e[3]);
      check("facing_left", facing_left, e[2]);
      check("anim_frame", anim_frame, e[1:0]);
    end
  endtask

  task automatic frame(input logic [31:0] kc, input logic [9:0] jym);
    @(negedge frame_clk);
    keycode = kc;
    jump_y_motion = jym;
    #1;
    check("jump_en", jump_en, model_jen(kc));
    if (jump_en === 1'b1) jen_pulses++;
    @(posedge frame_clk);
    model_step(kc, jym);
    #1;
    compare_outputs();
    if (on_ground === 1'b0) air_frames++;
  endtask

  // Reset lands between edges and is held across one edge; keycode is left as-is.
  task automatic apply_reset();
    @(negedge frame_clk);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    check("jump_en_in_reset", jump_en, model_jen(keycode));
    @(posedge frame_clk);
    #2;
    Reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] combos [9];
  int saved_x;

  initial begin
    combos[0] = K_NONE;  combos[1] = K_A;     combos[2] = K_D;
    combos[3] = K_AD;    combos[4] = K_W;     combos[5] = K_SPACE;
    combos[6] = 32'h0007_1A00;  combos[7] = 32'h2C00_0004;  combos[8] = 32'h0005_3300;

    // Single tap jump: one pulse, 40 airborne frames, lands at ground.
    apply_reset();
    frame(K_NONE, jy(0));
    jen_pulses = 0; air_frames = 0;
    frame(K_W, jy(0));
    for (int i = 0; i < 60; i++) frame(K_NONE, jy(i < 20 ? -8 : 8));
    check("tap_pulses", jen_pulses, 1);
    check("tap_air_frames", air_frames, T_JFRAMES);
    check("tap_land_y", mario_y, T_GROUND);

    // Held space for 100 frames fires once.
    apply_reset();
    frame(K_NONE, jy(0));
    jen_pulses = 0;
    for (int i = 0; i < 100; i++) frame(K_SPACE, jy($urandom_range(0, 10) - 5));
    check("held_space_pulses", jen_pulses, 1);

    // Right acceleration then saturation at the right edge.
    apply_reset();
    for (int i = 0; i < 12; i++) frame(K_D, jy(0));
    check("accel_x_after_12", mario_x, 76);
    for (int i = 0; i < 200; i++) frame(K_D, jy(0));
    check("right_edge_x", mario_x, T_XMAX);
    check("right_edge_face", facing_left, 0);

    // Both keys decay velocity to zero without turning left.
    apply_reset();
    for (int i = 0; i < 12; i++) frame(K_D, jy(0));
    for (int i = 0; i < 12; i++) frame(K_AD, jy(0));
    saved_x = mario_x;
    for (int i = 0; i < 4; i++) frame(K_AD, jy(0));
    check("decay_x_still", mario_x, saved_x);
    check("decay_face", facing_left, 0);

    // Left edge clamp keeps facing left.
    apply_reset();
    for (int i = 0; i < 60; i++) frame(K_A, jy(0));
    check("left_edge_x", mario_x, T_XMIN);
    check("left_edge_face", facing_left, 1);

    // Large vertical deltas clamp at 0 and at ground, no wrap.
    apply_reset();
    frame(K_NONE, jy(0));
    frame(K_W, jy(0));
    frame(K_NONE, jy(-500));
    check("clamp_top_y", mario_y, 0);
    frame(K_NONE, jy(-500));
    check("clamp_top_y_again", mario_y, 0);
    frame(K_NONE, jy(500));
    check("clamp_ground_y", mario_y, T_GROUND);
    for (int i = 0; i < 40; i++) frame(K_NONE, jy(0));
    check("clamp_landed", on_ground, 1);

    // Reset at air_cnt 20 with the jump key still held.
    apply_reset();
    frame(K_NONE, jy(0));
    frame(K_W, jy(0));
    for (int i = 0; i < 20; i++) frame(K_W, jy(-5));
    apply_reset();
    check("midjump_reset_y", mario_y, T_GROUND);
    check("midjump_reset_ground", on_ground, 1);
    jen_pulses = 0;
    for (int i = 0; i < 5; i++) frame(K_W, jy(0));
    check("midjump_held_pulses", jen_pulses, 0);
    frame(K_NONE, jy(0));
    frame(K_W, jy(0));
    check("midjump_repress_pulses", jen_pulses, 1);

    // Random held key segments with random vertical deltas.
    apply_reset();
    for (int s = 0; s < 40; s++) begin
      logic [31:0] kc;
      int len;
      kc = combos[$urandom_range(0, 8)];
      len = $urandom_range(1, 25);
      if (s == 20) apply_reset();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) frame(kc, jy($urandom_range(0, 1) ? 500 : -500));
        else frame(kc, jy($urandom_range(0, 24) - 12));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mario_motion.md
MARIO_MOTION -- requirements
Module: mario_motion

Interface
REQ-001 The block SHALL have parameter START_X, default 64, Mario's reset X position in pixels.
REQ-002 The block SHALL have parameter GROUND_Y, default 400, the Y coordinate of Mario's top edge when standing.
REQ-003 The block SHALL have parameter X_MIN, default 0, the left screen bound.
REQ-004 The block SHALL have parameter X_MAX, default 623, the rightmost legal X, equal to screen width minus sprite width.
REQ-005 The block SHALL have parameter MAX_VEL, default 3, the horizontal speed limit in pixels per frame.
REQ-006 The block SHALL have parameter JUMP_FRAMES, default 40, the length of the jump motion sequence supplied upstream.
REQ-007 The block SHALL have port frame_clk, input, 1 bit: the single clock, one rising edge per video frame.
REQ-008 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port keycode, input, 32 bits: four 8-bit USB HID keycodes.
REQ-010 The block SHALL have port jump_y_motion, input, 10 bits: two's-complement vertical delta from the jump sequencer.
REQ-011 The block SHALL have port jump_en, output, 1 bit: jump request to the jump sequencer.
REQ-012 The block SHALL have port mario_x, output, 10 bits: unsigned sprite X position.
REQ-013 The block SHALL have port mario_y, output, 10 bits: unsigned sprite Y position.
REQ-014 The block SHALL have port on_ground, output, 1 bit: high while in state GROUNDED.
REQ-015 The block SHALL have port facing_left, output, 1 bit: sprite mirror select.
REQ-016 The block SHALL have port anim_frame, output, 2 bits: walk animation index.

Function
REQ-017 Key decode SHALL set left when any keycode byte is 0x04 (A), right on 0x07 (D), and jump on 0x1A (W) or 0x2C (space).
REQ-018 The state machine SHALL have states GROUNDED and AIRBORNE, both registered on frame_clk.
REQ-019 jump_en SHALL be asserted combinationally only in GROUNDED when jump is high and jump_prev (jump registered from the previous frame) is low.
REQ-020 On the frame_clk edge where jump_en is high, the state SHALL change to AIRBORNE and air_cnt SHALL load 0.
REQ-021 In AIRBORNE, each edge SHALL apply mario_y <= mario_y + jump_y_motion and increment air_cnt.
REQ-022 On the edge where air_cnt equals JUMP_FRAMES-1 and the update is applied, the state SHALL return to GROUNDED and mario_y SHALL be forced to GROUNDED_Y.
REQ-023 Vertical arithmetic SHALL use 11-bit signed width, with a result above GROUND_Y clamped to GROUND_Y and a result below 0 clamped to 0.
REQ-024 A held jump key SHALL NOT re-trigger a jump; the key must be released for at least one frame first.
REQ-025 Horizontal velocity x_vel SHALL be 4-bit signed, range -MAX_VEL..+MAX_VEL, and updated once every 4 frames using a free-running 2-bit prescaler.
REQ-026 On a prescaler tick, x_vel SHALL step by 1 toward +MAX_VEL when only right is held, toward -MAX_VEL when only left is held, and toward 0 otherwise, including when both are held.
REQ-027 mario_x SHALL update every frame as mario_x + x_vel, in both states.
REQ-028 mario_x SHALL be clamped to [X_MIN, X_MAX], and x_vel SHALL be zeroed on the same edge that a clamp occurs.
REQ-029 facing_left SHALL be set when x_vel is less than 0, cleared when x_vel is greater than 0, and held when x_vel is 0.
REQ-030 anim_frame SHALL increment modulo 4 every 8 frames while GROUNDED and x_vel is nonzero, and SHALL be forced to 0 otherwise.
REQ-031 The only output latency SHALL be that mario_x and mario_y reflect inputs sampled at the previous edge; jump_en SHALL have zero latency.

Reset
REQ-032 On Reset_n low, the block SHALL asynchronously set state=GROUNDED, mario_x=START_X, mario_y=GROUND_Y, x_vel=0, air_cnt=0, prescaler=0, anim_frame=0, facing_left=0, and jump_prev=1.
REQ-033 Reset mid-jump SHALL abort the jump immediately, and jump_en SHALL stay low until jump is released and pressed again after reset.

Structure
REQ-034 The package mario_pkg SHALL hold the keycode constants and the motion_state_t enum.
REQ-035 Keycode decoding SHALL be the sub-module keycode_decode, which maps keycode[31:0] to left, right and jump.

Verification
REQ-036 Scenario: after reset, hold 0x1A for 1 frame -> jump_en high for exactly 1 frame, then AIRBORNE for 40 frames, then GROUNDED with mario_y=400.
REQ-037 Scenario: hold 0x2C for 100 frames -> exactly one jump_en pulse.
REQ-038 Scenario: hold 0x07 from mario_x=64 -> x_vel reaches 3 after 12 frames, and mario_x saturates at 623 with x_vel=0.
REQ-039 Scenario: hold 0x04 and 0x07 together while x_vel=3 -> x_vel decays to 0 within 12 frames, and facing_left stays 0.
REQ-040 Scenario: drive jump_y_motion=-500 while AIRBORNE -> mario_y clamps to 0 with no wrap.
REQ-041 Scenario: pull Reset_n low at air_cnt=20 -> mario_y=400, on_ground=1, and jump_en=0 while the jump key remains held.
